// File: rtl/wb_master_ctrl.sv
// Wishbone classic initiator: one local command becomes one bus transfer and one response.
// Optional ACK timeout compiled in when WB_MASTER_TIMEOUT_EN is defined.
module wb_master_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WE,
  input  logic [31:0] CMD_ADDR,
  input  logic [3:0]  CMD_SEL,
  input  logic [31:0] CMD_DATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_DATA,
  output logic        RSP_ERR,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_master_ctrl: TIMEOUT_CYCLES must be within 2..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            bus_q, bus_d;
  logic            we_q, we_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rsp_data_d = rsp_data_q;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          state_d = BUS;
          we_d    = CMD_WE;
          sel_d   = CMD_SEL;
          adr_d   = CMD_ADDR;
          dat_d   = CMD_DATA;
`ifdef WB_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
        if (ACK_I) begin
          state_d    = RESP;
          rsp_data_d = we_q ? '0 : DAT_I;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_err_d  = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = RESP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
`endif
        end
      end
      RESP: begin
        if (RSP_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake and bus strobes follow the state being entered, so they are flop outputs
    cmd_ready_d = (state_d == IDLE);
    bus_d       = (state_d == BUS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      bus_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      bus_q       <= bus_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign CYC_O     = bus_q;
  assign STB_O     = bus_q;
  assign WE_O      = we_q;
  assign SEL_O     = sel_q;
  assign ADR_O     = adr_q;
  assign DAT_O     = dat_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
`ifdef WB_MASTER_TIMEOUT_EN
  assign RSP_ERR   = rsp_err_q;
`else
  assign RSP_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Self-checking bench for wb_master_ctrl: behavioural Wishbone slave plus a word-memory reference model.
module tb_wb_master_ctrl;

  logic        clk = 1'b0;
  logic        RST_I, CMD_VALID, CMD_READY, CMD_WE;
  logic [31:0] CMD_ADDR, CMD_DATA;
  logic [3:0]  CMD_SEL;
  logic        RSP_VALID, RSP_READY, RSP_ERR;
  logic [31:0] RSP_DATA;
  logic        CYC_O, STB_O, WE_O;
  logic [3:0]  SEL_O;
  logic [31:0] ADR_O, DAT_O, DAT_I;
  logic        ACK_I;

  logic        slave_ack = 1'b0;
  logic        manual_ack;
  logic [31:0] slave_rdata = 32'h0;
  int          slave_lat = 1000;
  int          s_cnt = 0;
  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign ACK_I = slave_ack | manual_ack;
  assign DAT_I = slave_rdata;

  wb_master_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .CLK_I(clk), .RST_I(RST_I),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WE(CMD_WE),
    .CMD_ADDR(CMD_ADDR), .CMD_SEL(CMD_SEL), .CMD_DATA(CMD_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .SEL_O(SEL_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  function automatic logic [3:0] widx(input logic [31:0] a);
    return {a[7], a[4:2]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Reference: returns the response data a transfer should produce and updates the word memory
  function automatic logic [31:0] ref_access(input logic we, input logic [31:0] a, input logic [3:0] sel,
                                             input logic [31:0] d);
    if (we) begin
      ref_mem[widx(a)] = merge(ref_mem[widx(a)], d, sel);
      return 32'h0;
    end
    return ref_mem[widx(a)];
  endfunction

  // Slave: ACK after slave_lat wait cycles of CYC&STB; junk on DAT_I whenever not acking
  initial begin
    for (int i = 0; i < 16; i++) slv_mem[i] = 32'hC0DE_0000 | 32'(i);
    forever begin
      @(negedge clk);
      if (CYC_O === 1'b1 && STB_O === 1'b1) begin
        s_cnt++;
        if (s_cnt == slave_lat + 1) begin
          slave_ack = 1'b1;
          if (WE_O) begin
            slv_mem[widx(ADR_O)] = merge(slv_mem[widx(ADR_O)], DAT_O, SEL_O);
            slave_rdata = $urandom;
          end else begin
            slave_rdata = slv_mem[widx(ADR_O)];
          end
        end else begin
          slave_ack   = 1'b0;
          slave_rdata = $urandom;
        end
      end else begin
        s_cnt       = 0;
        slave_ack   = 1'b0;
        slave_rdata = $urandom;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transfer from IDLE back to IDLE; response held for 'hold' cycles with RSP_READY low
  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data,
                     input int lat, input int hold, output int ncyc, output logic [31:0] rdata,
                     output logic err);
    int   guard;
    logic bus_ok, hold_ok;
    slave_lat = lat;
    CMD_VALID = 1'b1; CMD_WE = we; CMD_ADDR = addr; CMD_SEL = sel; CMD_DATA = data;
    RSP_READY = 1'b0;
    chk1("cmd_ready_idle", CMD_READY, 1'b1);
    tick();
    CMD_VALID = 1'b0; CMD_WE = 1'($urandom); CMD_ADDR = $urandom; CMD_SEL = 4'($urandom);
    CMD_DATA = $urandom;
    ncyc = 0; guard = 0; bus_ok = 1'b1;
    while (RSP_VALID !== 1'b1 && guard < 100) begin
      if (CYC_O === 1'b1 && STB_O === 1'b1) ncyc++;
      if (!(CYC_O === 1'b1 && STB_O === 1'b1 && WE_O === we && ADR_O === addr && SEL_O === sel &&
            DAT_O === data && CMD_READY === 1'b0))
        bus_ok = 1'b0;
      tick();
      guard++;
    end
    chk1("rsp_arrives", RSP_VALID, 1'b1);
    chk1("bus_fields_stable", bus_ok, 1'b1);
    chk1("cyc_dropped_in_resp", CYC_O | STB_O, 1'b0);
    rdata = RSP_DATA;
    err = RSP_ERR;
    hold_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (!(RSP_VALID === 1'b1 && RSP_DATA === rdata && RSP_ERR === err && CMD_READY === 1'b0 &&
            CYC_O === 1'b0))
        hold_ok = 1'b0;
    end
    chk1("rsp_hold_stable", hold_ok, 1'b1);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk1("rsp_consumed", RSP_VALID, 1'b0);
    chk1("ready_after_rsp", CMD_READY, 1'b1);
  endtask

  initial begin
    int          ncyc;
    logic [31:0] rd, exp;
    logic        er, wev;
    logic [31:0] a, d;
    logic [3:0]  s;
    int          lat;
    logic        cyc_tr [20];
    logic [31:0] rsp_q [$];
    int          acc, r1, f1, r2, f2, rsp_cnt;

    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    RST_I = 1'b1; CMD_VALID = 1'b0; CMD_WE = 1'b0; CMD_ADDR = '0; CMD_SEL = '0; CMD_DATA = '0;
    RSP_READY = 1'b0; manual_ack = 1'b0;

    // Reset values
    tick(); tick();
    chk1("rst_cmd_ready", CMD_READY, 1'b0);
    chk1("rst_cyc", CYC_O, 1'b0);
    chk1("rst_stb", STB_O, 1'b0);
    chk1("rst_we", WE_O, 1'b0);
    chk32("rst_sel", 32'(SEL_O), 32'h0);
    chk32("rst_adr", ADR_O, 32'h0);
    chk32("rst_dat", DAT_O, 32'h0);
    chk1("rst_rsp_valid", RSP_VALID, 1'b0);
    chk32("rst_rsp_data", RSP_DATA, 32'h0);
    chk1("rst_rsp_err", RSP_ERR, 1'b0);
    RST_I = 1'b0;
    tick(); tick();
    chk1("post_rst_ready", CMD_READY, 1'b1);

    // Stray ACK in IDLE
    manual_ack = 1'b1;
    tick();
    manual_ack = 1'b0;
    chk1("idle_ack_cyc", CYC_O, 1'b0);
    chk1("idle_ack_rsp", RSP_VALID, 1'b0);
    chk1("idle_ack_ready", CMD_READY, 1'b1);
    tick();
    chk1("idle_ack_rsp2", RSP_VALID, 1'b0);

    // Directed write, slave ACK after two wait cycles
    exp = ref_access(1'b1, 32'h3000_0004, 4'hF, 32'hDEAD_BEEF);
    txn(1'b1, 32'h3000_0004, 4'hF, 32'hDEAD_BEEF, 2, 0, ncyc, rd, er);
    chk32("wr_cyc_len", 32'(ncyc), 32'd3);
    chk32("wr_rsp_data", rd, exp);
    chk1("wr_rsp_err", er, 1'b0);

    // Directed read of RAM window returning 0x12345678, response stalled 5 cycles
    exp = ref_access(1'b1, 32'h3000_0080, 4'hF, 32'h1234_5678);
    txn(1'b1, 32'h3000_0080, 4'hF, 32'h1234_5678, 2, 0, ncyc, rd, er);
    exp = ref_access(1'b0, 32'h3000_0080, 4'hF, 32'h0);
    txn(1'b0, 32'h3000_0080, 4'hF, 32'h0, 2, 5, ncyc, rd, er);
    chk32("rd_rsp_data", rd, 32'h1234_5678);
    chk32("rd_ref_data", rd, exp);
    chk32("rd_cyc_len", 32'(ncyc), 32'd3);

    // Back-to-back with CMD_VALID held: write then read of same word
    d = $urandom;
    exp = ref_access(1'b1, 32'h3000_0010, 4'hF, d);
    exp = ref_access(1'b0, 32'h3000_0010, 4'hF, 32'h0);
    slave_lat = 2; RSP_READY = 1'b1; acc = 0; rsp_cnt = 0;
    CMD_VALID = 1'b1; CMD_WE = 1'b1; CMD_ADDR = 32'h3000_0010; CMD_SEL = 4'hF; CMD_DATA = d;
    for (int c = 0; c < 20; c++) begin
      cyc_tr[c] = CYC_O;
      if (RSP_VALID === 1'b1) begin rsp_q.push_back(RSP_DATA); rsp_cnt++; end
      if (CMD_VALID && CMD_READY === 1'b1) acc++;
      tick();
      if (acc == 1) begin CMD_WE = 1'b0; CMD_DATA = 32'h0; end
      if (acc == 2) CMD_VALID = 1'b0;
    end
    RSP_READY = 1'b0;
    r1 = -1; f1 = -1; r2 = -1; f2 = -1;
    for (int c = 1; c < 20; c++) begin
      if (cyc_tr[c] === 1'b1 && cyc_tr[c-1] !== 1'b1) begin
        if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
      end
      if (cyc_tr[c] !== 1'b1 && cyc_tr[c-1] === 1'b1) begin
        if (f1 < 0) f1 = c; else if (f2 < 0) f2 = c;
      end
    end
    chk32("b2b_len1", 32'(f1 - r1), 32'd3);
    chk32("b2b_idle_gap", 32'(r2 - f1), 32'd2);
    chk32("b2b_len2", 32'(f2 - r2), 32'd3);
    chk32("b2b_rsp_count", 32'(rsp_cnt), 32'd2);
    if (rsp_cnt == 2) begin
      chk32("b2b_rsp0", rsp_q[0], 32'h0);
      chk32("b2b_rsp1", rsp_q[1], exp);
    end

`ifdef WB_MASTER_TIMEOUT_EN
    // No ACK: aborted after 16 BUS cycles
    txn(1'b0, 32'h3000_0008, 4'hF, 32'h0, 1000, 1, ncyc, rd, er);
    chk32("to_cyc_len", 32'(ncyc), 32'd16);
    chk1("to_err", er, 1'b1);
    chk32("to_data", rd, 32'h0);
    // ACK on the expiring cycle wins
    exp = ref_access(1'b0, 32'h3000_0008, 4'hF, 32'h0);
    txn(1'b0, 32'h3000_0008, 4'hF, 32'h0, 15, 0, ncyc, rd, er);
    chk32("to_ack_cyc_len", 32'(ncyc), 32'd16);
    chk1("to_ack_err", er, 1'b0);
    chk32("to_ack_data", rd, exp);
`else
    // Without the timeout, BUS waits as long as needed
    exp = ref_access(1'b0, 32'h3000_0008, 4'hF, 32'h0);
    txn(1'b0, 32'h3000_0008, 4'hF, 32'h0, 40, 0, ncyc, rd, er);
    chk32("long_wait_cyc_len", 32'(ncyc), 32'd41);
    chk1("long_wait_err", er, 1'b0);
    chk32("long_wait_data", rd, exp);
`endif

    // Reset during BUS: transfer dropped, no response
    slave_lat = 1000;
    CMD_VALID = 1'b1; CMD_WE = 1'b0; CMD_ADDR = 32'h3000_000C; CMD_SEL = 4'hF;
    tick();
    CMD_VALID = 1'b0;
    tick(); tick();
    chk1("mid_rst_in_bus", CYC_O, 1'b1);
    RST_I = 1'b1;
    tick();
    RST_I = 1'b0;
    chk1("mid_rst_cyc", CYC_O, 1'b0);
    chk1("mid_rst_stb", STB_O, 1'b0);
    chk1("mid_rst_rsp", RSP_VALID, 1'b0);
    tick();
    chk1("mid_rst_ready", CMD_READY, 1'b1);
    rsp_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (RSP_VALID !== 1'b0 || CYC_O !== 1'b0) rsp_cnt++;
    end
    chk32("mid_rst_quiet", 32'(rsp_cnt), 32'd0);

    // Randomized transfers against the reference memory
    for (int n = 0; n < 30; n++) begin
      wev = 1'($urandom);
      a   = ($urandom_range(0, 1) == 1 ? 32'h3000_0080 : 32'h3000_0000) + 32'(4 * $urandom_range(0, 7));
      s   = 4'($urandom);
      d   = $urandom;
      lat = int'($urandom_range(0, 4));
      exp = ref_access(wev, a, s, d);
      txn(wev, a, s, d, lat, int'($urandom_range(0, 3)), ncyc, rd, er);
      chk32("rnd_data", rd, exp);
      chk1("rnd_err", er, 1'b0);
      chk32("rnd_cyc_len", 32'(ncyc), 32'(lat + 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
